dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 156 +++++++++++++++
 tb/tb_dm_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Single-port word memory responder: accepts one request at a time, completes it
// after a fixed LATENCY with a one-cycle ack, and flags misaligned/out-of-range accesses.
module dm_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt;
    logic        accept;
    logic        enter_resp;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    logic        t_err;
    logic [AW-1:0] t_idx;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready      = 1'b1;
        ack        = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                ready = 1'b0;
                if (cnt == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ack = 1'b1;
                if (req) begin
                    accept  = 1'b1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        enter_resp = (state_d == RESP) && ((state_q == WAIT) || accept);
    end

    // With LATENCY=1 the commit happens on the acceptance edge itself, so the
    // transaction fields come straight from the inputs rather than the latches.
    always_comb begin
        t_we    = lat_we;
        t_addr  = lat_addr;
        t_wdata = lat_wdata;
        t_be    = lat_be;
        if (state_q != WAIT) begin
            t_we    = we;
            t_addr  = addr;
            t_wdata = wdata;
            t_be    = be;
        end
        t_err = (t_addr[1:0] != 2'b00) || (t_addr[31:2] >= DEPTH_W);
        t_idx = t_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= CNT_INIT;
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_be    <= be;
            end else if (state_q == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                err <= t_err;
                if (!t_we) begin
                    rdata <= t_err ? 32'd0 : mem[t_idx];
                end
            end else if (state_q == RESP) begin
                err <= 1'b0;
            end
        end
    end

    // Byte-gated write; erroneous accesses never touch the array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (enter_resp && t_we && !t_err) begin
            for (int b = 0; b < 4; b++) begin
                if (t_be[b]) begin
                    mem[t_idx][8*b +: 8] <= t_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a LATENCY=2 instance and a LATENCY=1 instance
// driven by directed steps, with a reference memory model feeding per-instance scoreboards.
module tb_dm_responder;

    localparam int LAT_A   = 2;
    localparam int DEPTH_A = 1024;
    localparam int LAT_B   = 1;
    localparam int DEPTH_B = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqA;
    logic        reqB;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        readyA, ackA, errA;
    logic [31:0] rdataA;
    logic        readyB, ackB, errB;
    logic [31:0] rdataB;

    typedef struct {
        logic        isRead;
        logic [31:0] rdata;
        logic        err;
        int          ackAt;
    } exp_t;

    exp_t        qA[$];
    exp_t        qB[$];
    logic [31:0] modelA [DEPTH_A];
    logic [31:0] modelB [DEPTH_B];
    logic [31:0] lastA;
    logic [31:0] lastB;

    int cycle      = 0;
    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int ackCountA  = 0;
    int ackCountB  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    dm_responder #(.LATENCY(LAT_A), .DEPTH(DEPTH_A)) dutA (
        .clk(clk), .reset(reset), .req(reqA), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ready(readyA), .ack(ackA),
        .rdata(rdataA), .err(errA)
    );

    dm_responder #(.LATENCY(LAT_B), .DEPTH(DEPTH_B)) dutB (
        .clk(clk), .reset(reset), .req(reqB), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ready(readyB), .ack(ackB),
        .rdata(rdataB), .err(errB)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clearModels();
        foreach (modelA[i]) modelA[i] = 32'd0;
        foreach (modelB[i]) modelB[i] = 32'd0;
        lastA = 32'd0;
        lastB = 32'd0;
        qA.delete();
        qB.delete();
    endtask

    // Reference model: applies the access to the model memory in acceptance order
    // and pushes what the DUT must show when it acks.
    task automatic predict(input int inst, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        exp_t        e;
        int          depth;
        int          lat;
        int          idx;
        logic [31:0] word;
        depth = inst ? DEPTH_B : DEPTH_A;
        lat   = inst ? LAT_B : LAT_A;
        e.err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(depth));
        idx   = e.err ? 0 : int'(a[31:2]);
        word  = inst ? modelB[idx] : modelA[idx];
        if (w && !e.err) begin
            for (int j = 0; j < 4; j++) begin
                if (b[j]) word[8*j +: 8] = d[8*j +: 8];
            end
            if (inst) modelB[idx] = word;
            else      modelA[idx] = word;
        end
        if (!w) begin
            if (inst) lastB = e.err ? 32'd0 : word;
            else      lastA = e.err ? 32'd0 : word;
        end
        e.isRead = !w;
        e.rdata  = inst ? lastB : lastA;
        e.ackAt  = cycle + lat;
        if (inst) qB.push_back(e);
        else      qA.push_back(e);
    endtask

    task automatic checkAck(input int inst, input logic a, input logic e,
                            input logic [31:0] rd, input logic rdy);
        exp_t  f;
        bit    have;
        string p;
        f    = '{isRead: 1'b0, rdata: 32'd0, err: 1'b0, ackAt: 0};
        p    = inst ? "B" : "A";
        have = inst ? (qB.size() != 0) : (qA.size() != 0);
        if (have) f = inst ? qB[0] : qA[0];
        checkOutput({p, ".ready"}, {31'd0, rdy}, {31'd0, !(have && f.ackAt > cycle)});
        if (a) begin
            if (!have) begin
                checkOutput({p, ".spurious_ack"}, {31'd0, a}, 32'd0);
            end else begin
                if (inst) begin
                    void'(qB.pop_front());
                    ackCountB++;
                end else begin
                    void'(qA.pop_front());
                    ackCountA++;
                end
                checkOutput({p, ".ack_cycle"}, 32'(cycle), 32'(f.ackAt));
                checkOutput({p, ".err"}, {31'd0, e}, {31'd0, f.err});
                checkOutput({p, ".rdata"}, rd, f.rdata);
            end
        end else if (have && f.ackAt <= cycle) begin
            checkOutput({p, ".missing_ack"}, {31'd0, a}, 32'd1);
            if (inst) void'(qB.pop_front());
            else      void'(qA.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkAck(0, ackA, errA, rdataA, readyA);
        checkAck(1, ackB, errB, rdataB, readyB);
    endtask

    task automatic applyStimulus(input int inst, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b);
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        if (inst) reqB = 1'b1;
        else      reqA = 1'b1;
        predict(inst, w, a, d, b);
        tick();
    endtask

    // Dropping req and scrambling the data lines shows in-flight transactions are latched.
    task automatic idleInputs();
        reqA  = 1'b0;
        reqB  = 1'b0;
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        be    = 4'($urandom);
    endtask

    task automatic access(input int inst, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        applyStimulus(inst, w, a, d, b);
        idleInputs();
        repeat (inst ? LAT_B : LAT_A) tick();
    endtask

    initial begin
        int base;
        reset = 1'b0;
        reqA  = 1'b0;
        reqB  = 1'b0;
        clearModels();

        // Requests presented while reset is low must be dropped.
        we    = 1'b1;
        addr  = 32'h0;
        wdata = 32'hFFFF_FFFF;
        be    = 4'hF;
        reqA  = 1'b1;
        reqB  = 1'b1;
        repeat (3) tick();
        checkOutput("A.reset_ack", {31'd0, ackA}, 32'd0);
        checkOutput("A.reset_err", {31'd0, errA}, 32'd0);
        checkOutput("A.reset_rdata", rdataA, 32'd0);
        checkOutput("B.reset_ack", {31'd0, ackB}, 32'd0);
        checkOutput("B.reset_err", {31'd0, errB}, 32'd0);
        checkOutput("B.reset_rdata", rdataB, 32'd0);
        idleInputs();
        reset = 1'b1;
        tick();

        $display("[TB] reset override and basic write/read");
        access(0, 1'b0, 32'h0, 32'h0, 4'hF);
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0);

        $display("[TB] partial writes");
        access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        access(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        access(0, 1'b0, 32'h20, 32'h0, 4'h0);
        access(0, 1'b1, 32'h20, 32'h9999_9999, 4'b0000);
        access(0, 1'b0, 32'h20, 32'h0, 4'h0);

        $display("[TB] error accesses");
        access(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
        access(0, 1'b0, 32'h13, 32'h0, 4'h0);
        access(0, 1'b1, 32'(DEPTH_A * 4), 32'h5555_AAAA, 4'hF);
        access(0, 1'b1, 32'h11, 32'h7777_7777, 4'hF);
        access(0, 1'b0, 32'h0, 32'h0, 4'h0);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0);

        $display("[TB] back-to-back with req held for six cycles");
        base = ackCountA;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                applyStimulus(0, 1'b1, 32'h100 + 32'(4 * (k / 2)), 32'hB0B0_0000 + 32'(k), 4'hF);
            end else begin
                we    = 1'b1;
                addr  = 32'h200 + 32'(4 * k);
                wdata = 32'hBAD0_0000 + 32'(k);
                be    = 4'hF;
                reqA  = 1'b1;
                tick();
            end
        end
        idleInputs();
        repeat (2) tick();
        checkOutput("A.b2b_ack_count", 32'(ackCountA - base), 32'd3);
        access(0, 1'b0, 32'h100, 32'h0, 4'h0);
        access(0, 1'b0, 32'h104, 32'h0, 4'h0);
        access(0, 1'b0, 32'h108, 32'h0, 4'h0);
        access(0, 1'b0, 32'h204, 32'h0, 4'h0);

        $display("[TB] reset during WAIT");
        applyStimulus(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
        idleInputs();
        reset = 1'b0;
        clearModels();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        access(0, 1'b0, 32'h40, 32'h0, 4'h0);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0);

        $display("[TB] LATENCY=1 instance");
        access(1, 1'b1, 32'h8, 32'h0102_0304, 4'hF);
        access(1, 1'b0, 32'h8, 32'h0, 4'h0);
        base = ackCountB;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1'b1, 32'(4 * k), 32'h5500_0000 + 32'(k * 32'h0101_0101),
                          (k == 2) ? 4'b1010 : 4'hF);
        end
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'(DEPTH_B * 4), 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(1, 1'b0, 32'hC, 32'h0, 4'h0);
        idleInputs();
        tick();
        checkOutput("B.b2b_ack_count", 32'(ackCountB - base), 32'd10);

        idleInputs();
        repeat (4) tick();
        checkOutput("A.pending", 32'(qA.size()), 32'd0);
        checkOutput("B.pending", 32'(qB.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
